mod_mul_il_ms: RTL and testbench
================================

# mod_mul_il_ms

Multi-step interleaved modular multiplier: computes y = a·b mod m, or y = a·a mod m in square mode, for NBITS-wide operands, retiring STEPS bits of the multiplier per clock. It succeeds the single-bit interleaved multiplier in the crypto library. It adds an unrolling parameter, a square mode, a busy/error handshake and an optional abort. It sits under the modular-exponentiation controller and is started by a one-cycle pulse.

## Interface
- NBITS, 2048: operand/modulus width in bits (≥2).
- STEPS, 1: multiplier bits processed per clock (1, 2 or 4); ITER = ceil(NBITS/STEPS).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_p  in  1  start pulse; sampled only in IDLE.
- op_sqr  in  1  0 = a·b mod m, 1 = a·a mod m (b ignored); sampled with start_p.
- a  in  NBITS  multiplicand; caller guarantees a < m.
- b  in  NBITS  multiplier; caller guarantees b < m.
- m  in  NBITS  modulus.
- abort_p  in  1  abort pulse (present only with MOD_MUL_IL_MS_ABORT_EN).
- y  out  NBITS  result register.
- busy  out  1  high while an operation is in progress.
- done_p  out  1  one-cycle completion pulse.
- err  out  1  set when m == 0; valid with done_p.

## Operation
- **States:** IDLE, RUN, DONE. State is registered, and all outputs are registered or decoded from state.
- **IDLE, start_p = 1:**
  - Latch a, m, and bsel = op_sqr ? a : b. bsel is zero-extended at the top to ITER·STEPS bits.
  - Clear the accumulator P (NBITS+2 bits) and load the counter with ITER−1.
  - Go to RUN.
  - If m == 0, go directly to DONE with err = 1 and y = 0.
- **RUN:** each cycle performs STEPS unrolled radix-2 steps, MSB of bsel first. Each step:
  - P = 2P + (bit ? a : 0).
  - If P ≥ m, P −= m.
  - If P ≥ m, P −= m.
  - Shift bsel left by 1.
  - Invariant after each step: P < m. NBITS+2 bits cover the 2P + a < 3m intermediate.
- **Leaving RUN:** when the counter == 0, load y with P[NBITS−1:0], clear err, and go to DONE. Otherwise decrement the counter.
- **DONE:** done_p = 1 for one cycle; go to IDLE on the next edge.
- **busy:** high in RUN and DONE, low in IDLE.
- **y:** held from DONE until the next completion; not altered during RUN.
- **start_p in RUN or DONE:** ignored; no queuing.
- **Operand inputs:** may change freely after the start edge.
- **rst:** returns to IDLE with y = 0, busy = 0, done_p = 0, err = 0, P = 0. It overrides everything, including mid-RUN; no done_p is emitted for the killed operation.
- **Precondition violation** (a ≥ m or b ≥ m): the result is undefined, but the block must still terminate after ITER cycles.

## Timing
- The start edge is edge 0. RUN occupies edges 1..ITER. done_p is high in the cycle following edge ITER. Latency is ITER+1 cycles from start sample to done_p.
- m == 0: done_p is high in the cycle after the start edge.
- Back-to-back operation: start_p is accepted in the cycle after done_p. Maximum throughput is one op per ITER+2 cycles.
- err and y are stable from the rising edge of done_p until the next completion or rst.
- The critical path is STEPS chained (add, compare-subtract, compare-subtract) stages. STEPS trades latency for frequency.

## Configuration
- **MOD_MUL_IL_MS_ABORT_EN defined:**
  - Input port abort_p exists.
  - abort_p = 1 in RUN forces IDLE on that edge. busy drops the following cycle; no done_p; y and err are unchanged.
  - abort_p is ignored in IDLE and DONE. rst has priority over abort_p.
- **Undefined:** the port is absent and RUN always runs to completion.

## Test plan
- NBITS=2048, STEPS=1, m=2013, a=1093, b=1999, op_sqr=0 → done_p 2049 cycles after the start edge, y=802, err=0, busy high for exactly 2049 cycles.
- Same operands, op_sqr=1, b=0 → y=940 (1093² mod 2013).
- NBITS=10, STEPS=4 (ITER=3, padded):
  - m=1021, a=1020, b=1020 → y=1, done_p 4 cycles after start.
  - m=1021, a=0, b=777 → y=0.
- m=0, any a/b → done_p one cycle after start, err=1, y=0. A following valid op clears err.
- start_p re-pulsed mid-RUN with different operands → ignored, original result returned. rst asserted mid-RUN → IDLE next cycle, all outputs 0, no done_p. A restart then gives the correct result.
- With MOD_MUL_IL_MS_ABORT_EN: abort_p at RUN cycle 5 → busy low after, no done_p, prior y retained. abort_p and rst together → reset behaviour.

Source files
------------

// File: rtl/mod_mul_il_ms.sv
// Interleaved modular multiplier y = a*b mod m (or a*a mod m), STEPS multiplier bits per clock.
// Optional abort input enabled by defining MOD_MUL_IL_MS_ABORT_EN.
module mod_mul_il_ms #(
  parameter int NBITS = 2048,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_p,
  input  logic             op_sqr,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
`ifdef MOD_MUL_IL_MS_ABORT_EN
  input  logic             abort_p,
`endif
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             done_p,
  output logic             err
);

  localparam int ITER = (NBITS + STEPS - 1) / STEPS;
  localparam int BW   = ITER * STEPS;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int PW   = NBITS + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_m;
  logic [BW-1:0]    r_bsel;
  logic [PW-1:0]    r_p;
  logic [CW-1:0]    r_cnt;
  logic [NBITS-1:0] r_y;
  logic             r_err;

  logic [PW-1:0]    w_p;
  logic [BW-1:0]    w_b;
  logic [NBITS-1:0] w_bsel_in;
  logic             w_abort;

`ifdef MOD_MUL_IL_MS_ABORT_EN
  assign w_abort = abort_p;
`else
  assign w_abort = 1'b0;
`endif

  assign w_bsel_in = op_sqr ? a : b;

  // STEPS chained double-and-add stages; two conditional subtracts keep P < m
  always_comb begin
    w_p = r_p;
    w_b = r_bsel;
    for (int s = 0; s < STEPS; s++) begin
      w_p = {w_p[NBITS:0], 1'b0} + (w_b[BW-1] ? {2'b00, r_a} : '0);
      if (w_p >= {2'b00, r_m}) w_p = w_p - {2'b00, r_m};
      if (w_p >= {2'b00, r_m}) w_p = w_p - {2'b00, r_m};
      w_b = {w_b[BW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_bsel  <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_p) begin
            r_a    <= a;
            r_m    <= m;
            r_bsel <= BW'(w_bsel_in);
            r_p    <= '0;
            r_cnt  <= CW'(ITER - 1);
            if (m == '0) begin
              r_y     <= '0;
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_p    <= w_p;
            r_bsel <= w_b;
            if (r_cnt == '0) begin
              r_y     <= w_p[NBITS-1:0];
              r_err   <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done_p = (r_state == S_DONE);
  assign y      = r_y;
  assign err    = r_err;

endmodule

// File: tb/tb_mod_mul_il_ms.sv
// Scoreboard bench for mod_mul_il_ms: a 2048-bit STEPS=1 instance and a 10-bit STEPS=4 instance.
// Abort checks are compiled in when MOD_MUL_IL_MS_ABORT_EN is defined.
module tb_mod_mul_il_ms;
  localparam int NB  = 2048;
  localparam int NS  = 10;
  localparam int ITB = 2048;
  localparam int ITS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          abort_p;
  logic          bg_start, bg_sqr, bg_busy, bg_done, bg_err;
  logic [NB-1:0] bg_a, bg_b, bg_m, bg_y;
  logic          sm_start, sm_sqr, sm_busy, sm_done, sm_err;
  logic [NS-1:0] sm_a, sm_b, sm_m, sm_y;

  typedef struct {
    logic [63:0] y;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  mod_mul_il_ms #(.NBITS(NB), .STEPS(1)) u_big (
    .clk(clk), .rst(rst), .start_p(bg_start), .op_sqr(bg_sqr),
    .a(bg_a), .b(bg_b), .m(bg_m),
`ifdef MOD_MUL_IL_MS_ABORT_EN
    .abort_p(abort_p),
`endif
    .y(bg_y), .busy(bg_busy), .done_p(bg_done), .err(bg_err)
  );

  mod_mul_il_ms #(.NBITS(NS), .STEPS(4)) u_small (
    .clk(clk), .rst(rst), .start_p(sm_start), .op_sqr(sm_sqr),
    .a(sm_a), .b(sm_b), .m(sm_m),
`ifdef MOD_MUL_IL_MS_ABORT_EN
    .abort_p(1'b0),
`endif
    .y(sm_y), .busy(sm_busy), .done_p(sm_done), .err(sm_err)
  );

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic drive(input bit big, input logic st, input logic sq,
                       input logic [63:0] av, input logic [63:0] bv, input logic [63:0] mv);
    if (big) begin
      bg_start = st; bg_sqr = sq;
      bg_a = NB'(av); bg_b = NB'(bv); bg_m = NB'(mv);
    end else begin
      sm_start = st; sm_sqr = sq;
      sm_a = NS'(av); sm_b = NS'(bv); sm_m = NS'(mv);
    end
  endtask

  task automatic set_start(input bit big, input logic st);
    if (big) bg_start = st;
    else     sm_start = st;
  endtask

  function automatic logic get_done(input bit big);
    return big ? bg_done : sm_done;
  endfunction

  function automatic logic get_busy(input bit big);
    return big ? bg_busy : sm_busy;
  endfunction

  function automatic logic get_err(input bit big);
    return big ? bg_err : sm_err;
  endfunction

  function automatic logic [NB-1:0] get_y(input bit big);
    return big ? bg_y : NB'(sm_y);
  endfunction

  // one operation: push expectation, start, wait bounded for done_p, pop and compare
  task automatic run_op(input string tag, input bit big,
                        input logic [63:0] av, input logic [63:0] bv, input logic [63:0] mv,
                        input bit sq, input bit glitch);
    exp_t e;
    exp_t got;
    int   k;
    int   nb;
    int   lim;
    int   exp_lat;
    e.err = (mv == 0);
    e.y   = (mv == 0) ? 64'd0 : (sq ? (av * av) % mv : (av * bv) % mv);
    sb.push_back(e);
    exp_lat = (mv == 0) ? 1 : (big ? ITB : ITS) + 1;
    lim     = exp_lat + 20;
    @(negedge clk);
    drive(big, 1'b1, sq, av, bv, mv);
    @(posedge clk); #1;
    drive(big, 1'b0, ~sq, 64'($urandom), 64'($urandom), 64'($urandom));
    k  = 0;
    nb = int'(get_busy(big));
    while (!get_done(big) && k < lim) begin
      if (glitch && k == 1) drive(big, 1'b1, ~sq, 64'($urandom), 64'($urandom), 64'($urandom));
      if (glitch && k == 2) set_start(big, 1'b0);
      @(posedge clk); #1;
      k++;
      nb += int'(get_busy(big));
    end
    set_start(big, 1'b0);
    check({tag, " latency"}, NB'(k + 1), NB'(exp_lat));
    check({tag, " busy_cycles"}, NB'(nb), NB'(exp_lat));
    got = sb.pop_front();
    check({tag, " y"}, get_y(big), NB'(got.y));
    check({tag, " err"}, NB'(get_err(big)), NB'(got.err));
    @(posedge clk); #1;
    check({tag, " idle_after"}, NB'({get_busy(big), get_done(big)}), NB'(0));
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      seen = seen | bg_done;
    end
    check(tag, NB'(seen), NB'(0));
  endtask

  initial begin
    rst     = 1'b1;
    abort_p = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset big", NB'({bg_busy, bg_done, bg_err}), NB'(0));
    check("reset big y", bg_y, NB'(0));
    check("reset small", NB'({sm_busy, sm_done, sm_err, sm_y}), NB'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op("big mul", 1'b1, 64'd1093, 64'd1999, 64'd2013, 1'b0, 1'b0);
    run_op("big sqr", 1'b1, 64'd1093, 64'd0, 64'd2013, 1'b1, 1'b0);
    run_op("big m0", 1'b1, 64'd7, 64'd9, 64'd0, 1'b0, 1'b0);
    run_op("sm neg1", 1'b0, 64'd1020, 64'd1020, 64'd1021, 1'b0, 1'b0);
    run_op("sm zero_a", 1'b0, 64'd0, 64'd777, 64'd1021, 1'b0, 1'b0);
    run_op("sm m0", 1'b0, 64'd5, 64'd3, 64'd0, 1'b0, 1'b0);
    run_op("sm after_m0", 1'b0, 64'd500, 64'd600, 64'd1019, 1'b0, 1'b0);
    run_op("sm glitch", 1'b0, 64'd900, 64'd33, 64'd1021, 1'b0, 1'b1);

    for (int i = 0; i < 25; i++) begin
      int unsigned mr, ar, br;
      mr = $urandom_range(1023, 1);
      ar = $urandom_range(mr - 1, 0);
      br = $urandom_range(mr - 1, 0);
      run_op("sm rand", 1'b0, 64'(ar), 64'(br), 64'(mr), 1'($urandom_range(1, 0)), 1'b0);
    end

    // reset in the middle of a long run
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 64'd1093, 64'd1999, 64'd2013);
    @(posedge clk); #1;
    set_start(1'b1, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrun rst flags", NB'({bg_busy, bg_done, bg_err}), NB'(0));
    check("midrun rst y", bg_y, NB'(0));
    @(negedge clk);
    rst = 1'b0;
    expect_no_done("midrun rst no_done", 30);
    run_op("big restart", 1'b1, 64'd1093, 64'd1999, 64'd2013, 1'b0, 1'b0);

`ifdef MOD_MUL_IL_MS_ABORT_EN
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 64'd1234, 64'd55, 64'd2011);
    @(posedge clk); #1;
    set_start(1'b1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    abort_p = 1'b1;
    @(posedge clk); #1;
    check("abort flags", NB'({bg_busy, bg_done, bg_err}), NB'(0));
    check("abort y kept", bg_y, NB'(802));
    @(negedge clk);
    abort_p = 1'b0;
    expect_no_done("abort no_done", 30);

    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 64'd1234, 64'd55, 64'd2011);
    @(posedge clk); #1;
    set_start(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort_p = 1'b1;
    rst     = 1'b1;
    @(posedge clk); #1;
    check("abort+rst flags", NB'({bg_busy, bg_done, bg_err}), NB'(0));
    check("abort+rst y", bg_y, NB'(0));
    @(negedge clk);
    abort_p = 1'b0;
    rst     = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
